// File: rtl/fp_pkg.sv
// fp_pkg: single-precision field widths, type and constants shared by the FP add scheduler.
package fp_pkg;
    localparam int FP_W   = 32;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    typedef logic [FP_W-1:0] fp32_t;
    localparam fp32_t FP_ONE = 32'h3F800000;
    localparam fp32_t FP_TWO = 32'h40000000;
endpackage

// File: rtl/fp_add_core.sv
// fp_add_core: combinational magnitude adder; truncates, result sign forced to 0.
module fp_add_core
    import fp_pkg::*;
(
    input  fp32_t a,
    input  fp32_t b,
    output fp32_t y
);
    logic               a_big;
    logic [EXP_W-1:0]   e_a, e_b, e_big, d;
    logic [FRAC_W:0]    m_big, m_small;
    logic [FRAC_W+1:0]  s;
    always_comb begin
        e_a     = a[FP_W-2:FRAC_W];
        e_b     = b[FP_W-2:FRAC_W];
        a_big   = e_a >= e_b;
        e_big   = a_big ? e_a : e_b;
        d       = a_big ? e_a - e_b : e_b - e_a;
        m_big   = a_big ? {|e_a, a[FRAC_W-1:0]} : {|e_b, b[FRAC_W-1:0]};
        m_small = a_big ? {|e_b, b[FRAC_W-1:0]} : {|e_a, a[FRAC_W-1:0]};
        s       = {1'b0, m_big} + {1'b0, m_small >> d};
        y       = {a[FP_W-1] & b[FP_W-1] & 1'b0,
                   s[FRAC_W+1] ? e_big + 1'b1 : e_big,
                   s[FRAC_W+1] ? s[FRAC_W:1] : s[FRAC_W-1:0]};
    end
endmodule

// File: rtl/fp_rr_arb.sv
// fp_rr_arb: combinational round-robin arbiter; searches upward from last+1 and wraps modulo N.
module fp_rr_arb #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic           en,
    input  logic [IDW-1:0] last,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid
);
    logic [IDW-1:0] j;
    always_comb begin
        gnt       = '0;
        gnt_id    = '0;
        gnt_valid = 1'b0;
        j         = '0;
        // Walk from farthest to nearest so the nearest pending requester wins.
        for (int k = N; k >= 1; k--) begin
            j = IDW'((int'(last) + k) % N);
            if (en && req[j]) begin
                gnt       = N'(1) << j;
                gnt_id    = j;
                gnt_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fp_add_sched.sv
// fp_add_sched: round-robin sharing of one FP adder among NREQ requesters,
// two-stage pipeline (operands, result) with a tagged, back-pressured result channel.
module fp_add_sched
    import fp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ),
    parameter int CNTW  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_data,
    output logic [IDW-1:0]        res_id,
    output logic                  busy,
    output logic [CNTW-1:0]       issued_cnt
);
    logic           s1_valid, s2_valid, s1_en, s2_en, gnt_valid;
    fp32_t          s1_a, s1_b, s2_data, sum, acc_a, acc_b;
    logic [IDW-1:0] s1_id, s2_id, last_grant, gnt_id;
    logic [NREQ-1:0] gnt;

    assign s2_en     = !s2_valid || res_ready;
    assign s1_en     = !s1_valid || s2_en;
    assign req_ready = gnt;
    assign acc_a     = req_a[int'(gnt_id)*WIDTH +: WIDTH];
    assign acc_b     = req_b[int'(gnt_id)*WIDTH +: WIDTH];
    assign res_valid = s2_valid;
    assign res_data  = s2_data;
    assign res_id    = s2_id;
    assign busy      = s1_valid || s2_valid;

    fp_rr_arb #(.N(NREQ), .IDW(IDW)) u_arb (
        .req       (req_valid),
        .en        (s1_en),
        .last      (last_grant),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    fp_add_core u_add (
        .a (s1_a),
        .b (s1_b),
        .y (sum)
    );

    // A grant implies the requester is valid, so gnt_valid is the accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_id      <= '0;
            s2_valid   <= 1'b0;
            s2_data    <= '0;
            s2_id      <= '0;
            last_grant <= IDW'(NREQ-1);
            issued_cnt <= '0;
        end else begin
            if (s1_en) begin
                s1_valid <= gnt_valid;
                if (gnt_valid) begin
                    s1_a       <= acc_a;
                    s1_b       <= acc_b;
                    s1_id      <= gnt_id;
                    last_grant <= gnt_id;
                    issued_cnt <= issued_cnt + 1'b1;
                end
            end
            if (s2_en) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= sum;
                    s2_id   <= s1_id;
                end
            end
        end
    end
endmodule

// File: tb/tb_fp_add_sched.sv
// tb_fp_add_sched: directed scenarios plus randomized traffic checked every cycle
// against a queue-based model of in-flight operations and an integer FP-add model.
module tb_fp_add_sched;
    import fp_pkg::*;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 4;
    localparam int W    = 32;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_a = '0;
    logic [NREQ*W-1:0]   req_b = '0;
    logic                res_valid;
    logic                res_ready = 1'b0;
    logic [W-1:0]        res_data;
    logic [IDW-1:0]      res_id;
    logic                busy;
    logic [CNTW-1:0]     issued_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {logic [31:0] d; int id; int age;} op_t;
    op_t             q[$];
    int              ptr = NREQ-1;
    int              cnt_m = 0;
    logic [NREQ-1:0] acc_mask = '0;
    int              g;
    logic            exp_rv;

    always #5 clk = ~clk;

    fp_add_sched #(.WIDTH(W), .NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .busy       (busy),
        .issued_cnt (issued_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Exact value = mantissa * 2^(exp-100) as an integer; renormalise the sum, truncating.
    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        longint va, vb, s;
        int p;
        va = longint'({1'b1, a[22:0]}) << (int'(a[30:23]) - 100);
        vb = longint'({1'b1, b[22:0]}) << (int'(b[30:23]) - 100);
        s  = va + vb;
        p  = 0;
        for (int i = 0; i < 63; i++) if (s[i]) p = i;
        return {1'b0, 8'(p - 23 + 100), 23'(s >> (p - 23))};
    endfunction

    // Exponents within 3 of each other and clear low fraction bits keep every sum exact.
    function automatic logic [31:0] rand_op();
        return {1'b0, 8'($urandom_range(124, 127)), 15'($urandom), 8'h00};
    endfunction

    always @(negedge clk) if (rst_n) begin
        exp_rv = q.size() > 0 && q[0].age >= 2;
        chk("res_valid", 32'(res_valid), 32'(exp_rv));
        chk("busy", 32'(busy), 32'(q.size() > 0));
        chk("issued_cnt", 32'(issued_cnt), cnt_m % (1 << CNTW));
        if (exp_rv) begin
            chk("res_data", res_data, q[0].d);
            chk("res_id", 32'(res_id), q[0].id);
        end
        g = -1;
        if (q.size() < 2 || res_ready)
            for (int k = 1; k <= NREQ; k++)
                if (g < 0 && req_valid[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
        chk("req_ready", 32'(req_ready), g >= 0 ? 1 << g : 0);
        if (exp_rv && res_ready) void'(q.pop_front());
        foreach (q[i]) q[i].age = q[i].age + 1;
        acc_mask = '0;
        if (g >= 0) begin
            q.push_back(op_t'{model_add(req_a[g*W +: W], req_b[g*W +: W]), g, 1});
            ptr = g;
            cnt_m++;
            acc_mask[g] = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_valid[i]    = 1'b1;
    endtask

    task automatic clear_model();
        q.delete();
        ptr      = NREQ-1;
        cnt_m    = 0;
        acc_mask = '0;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n     = 1'b0;
        clear_model();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_acc, n_res, seen2;
        chk("model 1+1", model_add(FP_ONE, FP_ONE), FP_TWO);
        chk("model 1.5+1.5", model_add(32'h3FC00000, 32'h3FC00000), 32'h40400000);
        chk("model 2+1", model_add(FP_TWO, FP_ONE), 32'h40400000);

        do_reset();
        res_ready = 1'b1;
        set_req(0, FP_ONE, FP_ONE);
        @(negedge clk);
        chk("t1 ready", 32'(req_ready), 1);
        step();
        req_valid[0] = 1'b0;
        step();
        @(negedge clk);
        chk("t1 res_valid", 32'(res_valid), 1);
        chk("t1 res_data", res_data, FP_TWO);
        chk("t1 res_id", 32'(res_id), 0);
        chk("t1 issued_cnt", 32'(issued_cnt), 1);
        step();

        do_reset();
        res_ready = 1'b1;
        set_req(0, FP_ONE, FP_ONE);
        set_req(1, FP_TWO, FP_ONE);
        set_req(2, 32'h3FC00000, 32'h3FC00000);
        set_req(3, FP_TWO, FP_TWO);
        seen2 = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k < 8) chk($sformatf("t2 grant%0d", k), 32'(req_ready), 1 << (k % 4));
            if (res_valid && res_id == 2) begin
                seen2++;
                chk("t2 req2 data", res_data, 32'h40400000);
            end
            step();
        end
        chk("t2 req2 results", seen2, 2);

        do_reset();
        res_ready = 1'b0;
        set_req(1, FP_TWO, FP_ONE);
        n_acc = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (req_ready[1]) n_acc++;
            if (k == 4) chk("t3 stalled ready", 32'(req_ready), 0);
            if (res_valid) chk("t3 stall data", res_data, 32'h40400000);
            step();
        end
        chk("t3 accepted in stall", n_acc, 2);
        res_ready = 1'b1;
        n_res = 0;
        for (int k = 0; k < 20 && (busy || req_valid != 0); k++) begin
            @(negedge clk);
            if (res_valid) n_res++;
            if (req_ready[1]) n_acc++;
            step();
            if (acc_mask[1]) req_valid[1] = 1'b0;
        end
        chk("t3 results vs accepts", n_res, n_acc);
        chk("t3 total accepts", n_acc, 3);
        chk("t3 drained", 32'(busy), 0);

        do_reset();
        res_ready = 1'b1;
        set_req(3, FP_ONE, FP_ONE);
        @(negedge clk);
        chk("t4 grant3", 32'(req_ready), 8);
        step();
        set_req(0, FP_ONE, FP_TWO);
        set_req(3, FP_TWO, FP_TWO);
        @(negedge clk);
        chk("t4 req0 next", 32'(req_ready), 1);
        step();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("t4 req3 next", 32'(req_ready), 8);
        step();
        req_valid = '0;

        do_reset();
        res_ready = 1'b0;
        set_req(0, FP_ONE, FP_TWO);
        step();
        step();
        @(negedge clk);
        chk("t5 full", 32'(res_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5 res_valid", 32'(res_valid), 0);
        chk("t5 busy", 32'(busy), 0);
        chk("t5 issued_cnt", 32'(issued_cnt), 0);
        req_valid = '0;
        clear_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, FP_ONE, FP_ONE);
        @(negedge clk);
        chk("t5 req0 priority", 32'(req_ready), 1);
        step();
        req_valid = '0;

        do_reset();
        res_ready = 1'b1;
        set_req(0, FP_ONE, FP_ONE);
        n_acc = 0;
        for (int k = 0; k < 40 && n_acc < 17; k++) begin
            @(negedge clk);
            if (req_ready[0]) n_acc++;
            step();
        end
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("t6 accepts", n_acc, 17);
        chk("t6 cnt wrap", 32'(issued_cnt), 1);
        step();

        do_reset();
        for (int k = 0; k < 600; k++) begin
            res_ready = $urandom_range(0, 3) != 0;
            for (int i = 0; i < NREQ; i++)
                if (!req_valid[i] || acc_mask[i]) begin
                    if ($urandom_range(0, 2) != 0) set_req(i, rand_op(), rand_op());
                    else req_valid[i] = 1'b0;
                end
            step();
        end
        res_ready = 1'b1;
        for (int k = 0; k < 50 && (busy || req_valid != 0); k++) begin
            for (int i = 0; i < NREQ; i++) if (acc_mask[i]) req_valid[i] = 1'b0;
            step();
        end
        chk("drain idle", 32'(busy || req_valid != 0), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
